seq_frame_tx: RTL and testbench

//  Serial frame transmitter, the sending end of the "0110" sync-word link. Its

---
 rtl/seq_frame_tx_if.sv | 12 +
 rtl/seq_frame_tx.sv | 147 ++++++++++++++
 tb/tb_seq_frame_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Parallel-word handshake between a payload source and the seq_frame_tx serializer.
// The master side offers the word and valid; the slave side answers with ready.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word 0110, then a bit-stuffed MSB-first payload,
// followed by an idle gap. The line rests at 1 whenever no frame is being sent.
module seq_frame_tx #(
    parameter int DATA_W   = 8,
    parameter int IDLE_GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_frame_tx_if.slave    tx,
    output logic             sout,
    output logic             sout_en,
    output logic             stuff,
    output logic             busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IDLE_GAP);
  localparam logic [3:0]    SYNC_WORD = 4'b0110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] shreg_r;
  logic [CW-1:0]     bit_cnt_r;
  logic [1:0]        sync_cnt_r;
  logic [GW-1:0]     gap_cnt_r;
  logic [2:0]        hist_r;
  logic              sout_r;
  logic              sout_en_r;
  logic              stuff_r;
  logic              busy_r;

  logic              pay_step_s;
  logic              need_stuff_s;
  logic              more_s;

  // The state register reflects the bit currently on the line, so ready follows IDLE directly.
  always_comb begin
    tx.tx_ready  = (state_r == IDLE);
    pay_step_s   = (state_r == DATA) || (state_r == STUFF) ||
                   ((state_r == SYNC) && (sync_cnt_r == 2'd0));
    need_stuff_s = (hist_r == 3'b011);
    more_s       = (bit_cnt_r != BIT_LAST);
  end

  // Frame sequencer: each edge chooses the next line bit and the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= {DATA_W{1'b0}};
      bit_cnt_r  <= {CW{1'b0}};
      sync_cnt_r <= 2'd0;
      gap_cnt_r  <= {GW{1'b0}};
      hist_r     <= 3'b111;
      sout_r     <= 1'b1;
      sout_en_r  <= 1'b0;
      stuff_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tx.tx_valid) begin
            state_r    <= SYNC;
            shreg_r    <= tx.tx_data;
            bit_cnt_r  <= {CW{1'b0}};
            sync_cnt_r <= 2'd1;
            sout_r     <= SYNC_WORD[3];
            sout_en_r  <= 1'b1;
            stuff_r    <= 1'b0;
            busy_r     <= 1'b1;
            hist_r     <= {hist_r[1:0], SYNC_WORD[3]};
          end else begin
            sout_r    <= 1'b1;
            sout_en_r <= 1'b0;
            stuff_r   <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        SYNC: begin
          // The 2-bit index wraps to 0 once all four sync bits are out.
          if (sync_cnt_r != 2'd0) begin
            sout_r     <= SYNC_WORD[2'd3 - sync_cnt_r];
            hist_r     <= {hist_r[1:0], SYNC_WORD[2'd3 - sync_cnt_r]};
            sync_cnt_r <= sync_cnt_r + 2'd1;
          end else begin
            sync_cnt_r <= 2'd0;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        DATA, STUFF: begin
          busy_r <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          sout_r    <= 1'b1;
          sout_en_r <= 1'b0;
          stuff_r   <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase

      // Shared payload step: stuff, next payload bit, or close the frame.
      if (pay_step_s) begin
        if (need_stuff_s) begin
          state_r   <= STUFF;
          sout_r    <= 1'b1;
          sout_en_r <= 1'b1;
          stuff_r   <= 1'b1;
          hist_r    <= {hist_r[1:0], 1'b1};
        end else if (more_s) begin
          state_r   <= DATA;
          sout_r    <= shreg_r[DATA_W-1];
          sout_en_r <= 1'b1;
          stuff_r   <= 1'b0;
          shreg_r   <= shreg_r << 1;
          bit_cnt_r <= bit_cnt_r + CW'(1);
          hist_r    <= {hist_r[1:0], shreg_r[DATA_W-1]};
        end else begin
          state_r   <= GAP;
          sout_r    <= 1'b1;
          sout_en_r <= 1'b0;
          stuff_r   <= 1'b0;
          gap_cnt_r <= GW'(1);
        end
      end
    end
  end

  assign sout    = sout_r;
  assign sout_en = sout_en_r;
  assign stuff   = stuff_r;
  assign busy    = busy_r;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: directed frames plus random payloads checked
// against a bit-level frame model built from the sync/stuffing rules.
module tb_seq_frame_tx;
  localparam int DW  = 8;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sout, sout_en, stuff, busy;
  int   total = 0;
  int   bad = 0;
  logic exp_bit[$];
  logic exp_stf[$];

  seq_frame_tx_if #(.DATA_W(DW)) txi ();

  seq_frame_tx #(.DATA_W(DW), .IDLE_GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .tx(txi.slave),
      .sout(sout), .sout_en(sout_en), .stuff(stuff), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line content of one frame: sync, then payload with stuffing after any 011.
  function automatic void build_frame(input logic [DW-1:0] d);
    logic [3:0] sw;
    logic [2:0] h;
    sw = 4'b0110;
    h  = 3'b111;
    exp_bit.delete();
    exp_stf.delete();
    for (int k = 3; k >= 0; k--) begin
      exp_bit.push_back(sw[k]); exp_stf.push_back(1'b0); h = {h[1:0], sw[k]};
    end
    for (int i = DW - 1; i >= 0; i--) begin
      if (h == 3'b011) begin
        exp_bit.push_back(1'b1); exp_stf.push_back(1'b1); h = {h[1:0], 1'b1};
      end
      exp_bit.push_back(d[i]); exp_stf.push_back(1'b0); h = {h[1:0], d[i]};
    end
    if (h == 3'b011) begin
      exp_bit.push_back(1'b1); exp_stf.push_back(1'b1);
    end
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"}, sout, 1'b1);
    chk({tag, "_en"}, sout_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdy"}, txi.tx_ready, 1'b1);
  endtask

  // Present a word and step to the negedge where its first sync bit is on the line.
  task automatic send(input logic [DW-1:0] d, input bit keep);
    int n;
    txi.tx_data  = d;
    txi.tx_valid = 1'b1;
    n = 0;
    while (txi.tx_ready !== 1'b1 && n < 64) begin
      @(negedge clk); n++;
    end
    chk("ready_wait", {31'd0, txi.tx_ready}, 32'd1);
    @(negedge clk);
    if (!keep) begin
      txi.tx_valid = 1'b0;
      txi.tx_data  = DW'($urandom);
    end
  endtask

  // Walk one frame from its first sync bit through the gap into IDLE.
  task automatic check_frame(input logic [DW-1:0] d, input int exp_len);
    int i;
    int fires;
    logic [3:0] win;
    int since;
    build_frame(d);
    i = 0; fires = 0; win = 4'b1111; since = 0;
    while (sout_en === 1'b1 && i < 2 * DW + 8) begin
      if (i < exp_bit.size()) begin
        chk($sformatf("bit%0d_%02h", i, d), sout, exp_bit[i]);
        chk($sformatf("stf%0d_%02h", i, d), stuff, exp_stf[i]);
      end else begin
        chk($sformatf("extra%0d_%02h", i, d), 32'd1, 32'd0);
      end
      chk("busy_frame", busy, 1'b1);
      chk("rdy_frame", txi.tx_ready, 1'b0);
      win = {win[2:0], sout};
      since++;
      if (win == 4'b0110 && since >= 4) begin
        fires++; since = 0;
      end
      i++;
      @(negedge clk);
    end
    chk($sformatf("len_%02h", d), i, exp_len);
    chk($sformatf("det_%02h", d), fires, 1);
    for (int g = 0; g < GAP; g++) begin
      chk("gap_sout", sout, 1'b1);
      chk("gap_en", sout_en, 1'b0);
      chk("gap_busy", busy, 1'b1);
      chk("gap_rdy", txi.tx_ready, 1'b0);
      @(negedge clk);
    end
    chk_idle("post_gap");
  endtask

  initial begin
    logic [DW-1:0] d;
    txi.tx_valid = 1'b0;
    txi.tx_data  = {DW{1'b0}};
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle");

    send(8'h00, 1'b0); check_frame(8'h00, 12);
    send(8'hFF, 1'b0); check_frame(8'hFF, 13);
    send(8'h66, 1'b0); check_frame(8'h66, 14);
    send(8'h03, 1'b0); check_frame(8'h03, 13);

    // Back-to-back: valid stays high, second word takes over after the first acceptance.
    send(8'hA5, 1'b1);
    txi.tx_data = 8'h5A;
    build_frame(8'hA5);
    check_frame(8'hA5, exp_bit.size());
    @(negedge clk);
    txi.tx_valid = 1'b0;
    build_frame(8'h5A);
    check_frame(8'h5A, exp_bit.size());
    @(negedge clk);
    chk_idle("no_dup");

    // Reset while payload bit 3 is on the line.
    send(8'hB4, 1'b0);
    repeat (6) @(negedge clk);
    chk("pre_rst_en", sout_en, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("mid_rst");
    @(negedge clk);
    chk_idle("after_rst");
    send(8'hFF, 1'b0); check_frame(8'hFF, 13);

    for (int r = 0; r < 24; r++) begin
      d = DW'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, 1'b0);
      build_frame(d);
      check_frame(d, exp_bit.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
